// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage with PCF, a single-entry fetch buffer
// and the IF/ID pipeline register feeding decode.
//  - One imem request may be outstanding at a time.
//  - A request is granted in S_REQ, its response arrives in S_WAIT, and a
//    response orphaned by a redirect is swallowed in S_DRAIN.
//  - Decode fields are sliced combinationally from the IF/ID instruction.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        BranchTakenE,
  input  logic [31:0] ALUResultE,
  input  logic        PCSrcW,
  input  logic [31:0] ResultW,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic [1:0]  RegSrcD,
  output logic [31:0] inst_bus,
  output logic [31:0] pc_plus8_d,
  output logic        valid_d,
  output logic [3:0]  Cond,
  output logic [1:0]  Op,
  output logic [5:0]  Funct,
  output logic [3:0]  Rd,
  output logic [3:0]  ra1d,
  output logic [3:0]  ra2d,
  output logic        fetch_bubble
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pcp8_q, pcp8_d;
  logic        valid_q, valid_d_s;
  logic        bubble_q, bubble_d;

  logic        redirect_s;
  logic [31:0] target_s;
  logic        consume_s;
  logic        req_s;
  logic        grant_s;
  logic        fill_s;

  // Redirect detection; the execute-stage branch wins over a writeback R15 write.
  always_comb begin
    redirect_s = BranchTakenE | PCSrcW;
    if (BranchTakenE) begin
      target_s = ALUResultE;
    end else begin
      target_s = ResultW;
    end
  end

  // The IF/ID register drains the buffer only when neither flushed nor stalled.
  always_comb begin
    consume_s = buf_valid_q & ~FlushD & ~StallD;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        if (grant_s) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          // Kept or discarded, the response closes the transaction.
          state_d = S_REQ;
        end else if (redirect_s) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // FSM outputs: request qualification, grant and buffer-fill strobes.
  always_comb begin
    req_s   = 1'b0;
    fill_s  = 1'b0;
    case (state_q)
      S_REQ: begin
        req_s  = ~StallF & ~redirect_s & (~buf_valid_q | consume_s);
        fill_s = 1'b0;
      end
      S_WAIT: begin
        req_s  = 1'b0;
        fill_s = imem_rvalid & ~redirect_s;
      end
      S_DRAIN: begin
        req_s  = 1'b0;
        fill_s = 1'b0;
      end
      default: begin
        req_s  = 1'b0;
        fill_s = 1'b0;
      end
    endcase
    grant_s = req_s & imem_gnt;
  end

  assign imem_req  = req_s;
  assign imem_addr = pcf_q;

  // PCF and the address of the outstanding request.
  always_comb begin
    pcf_d    = pcf_q;
    req_pc_d = req_pc_q;
    if (redirect_s) begin
      pcf_d = target_s;
    end else if (grant_s) begin
      pcf_d = pcf_q + 32'd4;
    end else begin
      pcf_d = pcf_q;
    end
    if (grant_s) begin
      req_pc_d = pcf_q;
    end else begin
      req_pc_d = req_pc_q;
    end
  end

  // Fetch buffer: redirect clears it, a kept response fills it, decode drains it.
  always_comb begin
    buf_d       = buf_q;
    buf_pc_d    = buf_pc_q;
    buf_valid_d = buf_valid_q;
    if (redirect_s) begin
      buf_valid_d = 1'b0;
    end else if (fill_s) begin
      buf_d       = imem_rdata;
      buf_pc_d    = req_pc_q;
      buf_valid_d = 1'b1;
    end else if (consume_s) begin
      buf_valid_d = 1'b0;
    end else begin
      buf_valid_d = buf_valid_q;
    end
  end

  // Fetch-side registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcf_q       <= RESET_PC;
      req_pc_q    <= RESET_PC;
      buf_q       <= NOP_INSTR;
      buf_pc_q    <= RESET_PC;
      buf_valid_q <= 1'b0;
    end else begin
      pcf_q       <= pcf_d;
      req_pc_q    <= req_pc_d;
      buf_q       <= buf_d;
      buf_pc_q    <= buf_pc_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  // IF/ID next state: flush beats stall, stall beats load, else insert a bubble.
  always_comb begin
    inst_d    = inst_q;
    pcp8_d    = pcp8_q;
    valid_d_s = valid_q;
    bubble_d  = 1'b0;
    if (FlushD) begin
      inst_d    = NOP_INSTR;
      valid_d_s = 1'b0;
    end else if (StallD) begin
      inst_d    = inst_q;
      valid_d_s = valid_q;
    end else if (buf_valid_q) begin
      inst_d    = buf_q;
      pcp8_d    = buf_pc_q + 32'd8;
      valid_d_s = 1'b1;
    end else begin
      inst_d    = NOP_INSTR;
      valid_d_s = 1'b0;
      bubble_d  = 1'b1;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q   <= NOP_INSTR;
      pcp8_q   <= RESET_PC + 32'd8;
      valid_q  <= 1'b0;
      bubble_q <= 1'b0;
    end else begin
      inst_q   <= inst_d;
      pcp8_q   <= pcp8_d;
      valid_q  <= valid_d_s;
      bubble_q <= bubble_d;
    end
  end

  assign inst_bus     = inst_q;
  assign pc_plus8_d   = pcp8_q;
  assign valid_d      = valid_q;
  assign fetch_bubble = bubble_q;

  // Decode fields and register-read addresses.
  always_comb begin
    Cond  = inst_q[31:28];
    Op    = inst_q[27:26];
    Funct = inst_q[25:20];
    Rd    = inst_q[15:12];
    if (RegSrcD[0]) begin
      ra1d = 4'd15;
    end else begin
      ra1d = inst_q[19:16];
    end
    if (RegSrcD[1]) begin
      ra2d = inst_q[15:12];
    end else begin
      ra2d = inst_q[3:0];
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage.
// Inputs are driven on the falling edge and outputs are checked 1ns later,
// so each record shows the state left by earlier rising edges plus the
// combinational response to that record's own inputs.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        BranchTakenE;
  logic [31:0] ALUResultE;
  logic        PCSrcW;
  logic [31:0] ResultW;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic [1:0]  RegSrcD;
  logic [31:0] inst_bus;
  logic [31:0] pc_plus8_d;
  logic        valid_d;
  logic [3:0]  Cond;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic [3:0]  Rd;
  logic [3:0]  ra1d;
  logic [3:0]  ra2d;
  logic        fetch_bubble;

  int n_cmp;
  int n_bad;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE),
    .PCSrcW(PCSrcW), .ResultW(ResultW),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .RegSrcD(RegSrcD),
    .inst_bus(inst_bus), .pc_plus8_d(pc_plus8_d), .valid_d(valid_d),
    .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd), .ra1d(ra1d), .ra2d(ra2d),
    .fetch_bubble(fetch_bubble)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        br;
    logic [31:0] alu;
    logic        pcs;
    logic [31:0] res;
    logic        sf;
    logic        sd;
    logic        fd;
    logic [1:0]  rs;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_inst;
    logic [31:0] e_pcp8;
    logic        e_valid;
    logic        e_bub;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic gnt, input logic rv, input logic [31:0] rdata,
    input logic br, input logic [31:0] alu, input logic pcs, input logic [31:0] res,
    input logic sf, input logic sd, input logic fd, input logic [1:0] rs,
    input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_inst,
    input logic [31:0] e_pcp8, input logic e_valid, input logic e_bub);
    vec_t v;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.br = br; v.alu = alu; v.pcs = pcs; v.res = res;
    v.sf = sf; v.sd = sd; v.fd = fd; v.rs = rs;
    v.e_req = e_req; v.e_addr = e_addr; v.e_inst = e_inst;
    v.e_pcp8 = e_pcp8; v.e_valid = e_valid; v.e_bub = e_bub;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0000_0000;
    BranchTakenE = 1'b0; ALUResultE = 32'h0000_0000;
    PCSrcW = 1'b0; ResultW = 32'h0000_0000;
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; RegSrcD = 2'b00;
  endtask

  initial begin
    logic [31:0] ei;
    logic [3:0]  e_ra1;
    logic [3:0]  e_ra2;
    n_cmp = 0;
    n_bad = 0;

    //                gnt  rv    rdata         br    alu           pcs   res           sf    sd    fd    rs      req   addr          inst          pc+8          vd    bub
    // Test 1: back-to-back fetch of 0 and 4
    vecs[0]  = mk(1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,2'd0,  1'b1,32'h00,      NOP,          32'h08,       1'b0,1'b0);
    vecs[1]  = mk(1'b0,1'b1,32'hE2811001, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,2'd1,  1'b0,32'h04,      NOP,          32'h08,       1'b0,1'b1);
    vecs[2]  = mk(1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,2'd0,  1'b1,32'h04,      NOP,          32'h08,       1'b0,1'b1);
    vecs[3]  = mk(1'b0,1'b1,32'hE2822002, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,2'd2,  1'b0,32'h08,      32'hE2811001, 32'h08,       1'b1,1'b0);
    vecs[4]  = mk(1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,2'd3,  1'b1,32'h08,      NOP,          32'h08,       1'b0,1'b1);
    // Test 2: branch to 0x40 while waiting on address 8, FlushD pulsed, stale response drained
    vecs[5]  = mk(1'b0,1'b0,32'h0,        1'b1,32'h40,       1'b0,32'h0,        1'b0,1'b0,1'b1,2'd1,  1'b0,32'h0C,      32'hE2822002, 32'h0C,       1'b1,1'b0);
    vecs[6]  = mk(1'b0,1'b1,32'hDEADBEEF, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,2'd0,  1'b0,32'h40,      NOP,          32'h0C,       1'b0,1'b0);
    vecs[7]  = mk(1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,2'd0,  1'b1,32'h40,      NOP,          32'h0C,       1'b0,1'b1);
    vecs[8]  = mk(1'b0,1'b1,32'hE3A01005, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,2'd0,  1'b0,32'h44,      NOP,          32'h0C,       1'b0,1'b1);
    vecs[9]  = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,2'd0,  1'b1,32'h44,      NOP,          32'h0C,       1'b0,1'b1);
    // Test 3: branch and R15 write together, branch target wins; redirect masks the request
    vecs[10] = mk(1'b1,1'b0,32'h0,        1'b1,32'h80,       1'b1,32'h100,      1'b0,1'b0,1'b0,2'd2,  1'b0,32'h44,      32'hE3A01005, 32'h48,       1'b1,1'b0);
    vecs[11] = mk(1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,2'd0,  1'b1,32'h80,      NOP,          32'h48,       1'b0,1'b1);
    // Test 4: StallD for three cycles while the buffer fills
    vecs[12] = mk(1'b0,1'b1,32'hE0812003, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1,1'b0,2'd0,  1'b0,32'h84,      NOP,          32'h48,       1'b0,1'b1);
    vecs[13] = mk(1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1,1'b0,2'd0,  1'b0,32'h84,      NOP,          32'h48,       1'b0,1'b0);
    vecs[14] = mk(1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1,1'b0,2'd0,  1'b0,32'h84,      NOP,          32'h48,       1'b0,1'b0);
    vecs[15] = mk(1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,2'd0,  1'b1,32'h84,      NOP,          32'h48,       1'b0,1'b0);
    // Test 5: memory withholds rvalid for five cycles
    vecs[16] = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,2'd3,  1'b0,32'h88,      32'hE0812003, 32'h88,       1'b1,1'b0);
    vecs[17] = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,2'd0,  1'b0,32'h88,      NOP,          32'h88,       1'b0,1'b1);
    vecs[18] = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,2'd0,  1'b0,32'h88,      NOP,          32'h88,       1'b0,1'b1);
    vecs[19] = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,2'd0,  1'b0,32'h88,      NOP,          32'h88,       1'b0,1'b1);
    vecs[20] = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,2'd0,  1'b0,32'h88,      NOP,          32'h88,       1'b0,1'b1);
    vecs[21] = mk(1'b0,1'b1,32'hE2833003, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,2'd0,  1'b0,32'h88,      NOP,          32'h88,       1'b0,1'b1);
    vecs[22] = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,2'd0,  1'b1,32'h88,      NOP,          32'h88,       1'b0,1'b1);
    // StallF suppresses the request; then redirect and rvalid in the same cycle
    vecs[23] = mk(1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b0,1'b0,2'd1,  1'b0,32'h88,      32'hE2833003, 32'h8C,       1'b1,1'b0);
    vecs[24] = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,2'd0,  1'b1,32'h88,      NOP,          32'h8C,       1'b0,1'b1);
    vecs[25] = mk(1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,2'd0,  1'b1,32'h88,      NOP,          32'h8C,       1'b0,1'b1);
    vecs[26] = mk(1'b0,1'b1,32'hFFFFFFFF, 1'b0,32'h0,        1'b1,32'h200,      1'b0,1'b0,1'b0,2'd0,  1'b0,32'h8C,      NOP,          32'h8C,       1'b0,1'b1);
    vecs[27] = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,2'd0,  1'b1,32'h200,     NOP,          32'h8C,       1'b0,1'b1);

    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      imem_gnt = vecs[i].gnt; imem_rvalid = vecs[i].rv; imem_rdata = vecs[i].rdata;
      BranchTakenE = vecs[i].br; ALUResultE = vecs[i].alu;
      PCSrcW = vecs[i].pcs; ResultW = vecs[i].res;
      StallF = vecs[i].sf; StallD = vecs[i].sd; FlushD = vecs[i].fd; RegSrcD = vecs[i].rs;
      #1;
      ei    = vecs[i].e_inst;
      e_ra1 = vecs[i].rs[0] ? 4'd15 : ei[19:16];
      e_ra2 = vecs[i].rs[1] ? ei[15:12] : ei[3:0];
      chk($sformatf("v%0d_req", i),    {31'd0, imem_req},     {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d_addr", i),   imem_addr,             vecs[i].e_addr);
      chk($sformatf("v%0d_inst", i),   inst_bus,              ei);
      chk($sformatf("v%0d_pcp8", i),   pc_plus8_d,            vecs[i].e_pcp8);
      chk($sformatf("v%0d_valid", i),  {31'd0, valid_d},      {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_bubble", i), {31'd0, fetch_bubble}, {31'd0, vecs[i].e_bub});
      chk($sformatf("v%0d_fields", i), {14'd0, Cond, Op, Funct, Rd},
          {14'd0, ei[31:28], ei[27:26], ei[25:20], ei[15:12]});
      chk($sformatf("v%0d_ra", i),     {24'd0, ra1d, ra2d},   {24'd0, e_ra1, e_ra2});
    end

    // Test 6: reset while waiting on address 0x200; stale rvalid after reset
    @(negedge clk);
    idle_inputs();
    imem_gnt = 1'b1;
    #1;
    chk("rst_pre_req",  {31'd0, imem_req}, 32'd1);
    chk("rst_pre_addr", imem_addr, 32'h200);

    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("rst_wait_req", {31'd0, imem_req}, 32'd0);

    @(negedge clk);
    reset = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    #1;
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_req",   {31'd0, imem_req}, 32'd1);
    chk("rst_inst",  inst_bus, NOP);
    chk("rst_pcp8",  pc_plus8_d, 32'h8);
    chk("rst_valid", {31'd0, valid_d}, 32'd0);
    chk("rst_bub",   {31'd0, fetch_bubble}, 32'd0);

    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0000_0000;
    #1;
    chk("stale_addr", imem_addr, 32'h0);
    chk("stale_req",  {31'd0, imem_req}, 32'd1);
    chk("stale_bub1", {31'd0, fetch_bubble}, 32'd1);

    @(negedge clk);
    #1;
    chk("stale_inst",  inst_bus, NOP);
    chk("stale_valid", {31'd0, valid_d}, 32'd0);
    chk("stale_bub2",  {31'd0, fetch_bubble}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register that feed the pipelined controller and register file.
- Owns PCF and the instruction-memory request/response handshake.
- Holds one fetched instruction in a single-entry fetch buffer.
- Applies branch/PC-write redirects, StallF/StallD and FlushD.
- Presents the decode-stage instruction and its extracted fields (inst_bus, Cond, Op, Funct, Rd, ra1d, ra2d) to the decode stage.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
NOP_INSTR, 32'hE1A00000, instruction injected as a bubble (MOV R0,R0, cond AL).

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  request valid; address on imem_addr
imem_addr  out  32  request address (always PCF)
imem_gnt  in  1  request accepted this cycle (meaningful only while imem_req=1)
imem_rvalid  in  1  response data valid
imem_rdata  in  32  response instruction word
BranchTakenE  in  1  execute-stage branch taken
ALUResultE  in  32  branch target
PCSrcW  in  1  writeback writes R15
ResultW  in  32  R15 write value
StallF  in  1  hold fetch: no new request issued
StallD  in  1  hold IF/ID register
FlushD  in  1  load bubble into IF/ID
RegSrcD  in  2  register-source select from controller
inst_bus  out  32  decode-stage instruction
pc_plus8_d  out  32  decode PC + 8 (R15 read value)
valid_d  out  1  inst_bus holds a real instruction
Cond  out  4  inst_bus[31:28]
Op  out  2  inst_bus[27:26]
Funct  out  6  inst_bus[25:20]
Rd  out  4  inst_bus[15:12]
ra1d  out  4  RegSrcD[0] ? 15 : inst_bus[19:16]
ra2d  out  4  RegSrcD[1] ? inst_bus[15:12] : inst_bus[3:0]
fetch_bubble  out  1  IF/ID loaded a bubble because the fetch buffer was empty

Behaviour:
Reset values:
- PCF=RESET_PC; state=S_REQ; fetch buffer empty.
- inst_bus=NOP_INSTR; pc_plus8_d=RESET_PC+8; valid_d=0; fetch_bubble=0.

Redirect:
- redirect = BranchTakenE | PCSrcW.
- Target = BranchTakenE ? ALUResultE : ResultW; BranchTakenE has priority when both are set.
- On redirect: PCF<=target and the fetch buffer is cleared.
- redirect overrides StallF.

FSM:
- S_REQ:
  - imem_req = ~StallF & ~redirect & (buffer empty | buffer consumed this cycle).
  - On imem_gnt: req_pc<=PCF, PCF<=PCF+4 (modulo 2^32), next state S_WAIT.
  - imem_rvalid received in S_REQ is ignored.
- S_WAIT:
  - On imem_rvalid without redirect: buffer<=imem_rdata, buffer_pc<=req_pc, buffer valid; next state S_REQ.
  - On redirect without imem_rvalid: next state S_DRAIN.
  - On redirect and imem_rvalid in the same cycle: data discarded; next state S_REQ.
- S_DRAIN:
  - imem_req=0.
  - The next imem_rvalid is discarded; next state S_REQ.
  - A further redirect in S_DRAIN only updates PCF.
- Only one request is outstanding at a time. imem_addr is stable while imem_req=1 and gnt is low, except on a redirect, which deasserts imem_req that cycle.

IF/ID register (evaluated in priority order):
- reset: reset values above.
- FlushD: inst_bus<=NOP_INSTR, valid_d<=0. Buffer not consumed. Applies even when StallD is set.
- StallD: hold all IF/ID outputs; buffer not consumed.
- buffer valid: inst_bus<=buffer, pc_plus8_d<=buffer_pc+8, valid_d<=1. Buffer consumed (emptied unless refilled the same cycle).
- otherwise: inst_bus<=NOP_INSTR, valid_d<=0, fetch_bubble<=1.
- fetch_bubble is 0 in every other cycle.

Other rules:
- Decode fields are combinational from inst_bus and RegSrcD.
- Fetch latency: minimum 2 cycles from grant to the instruction being valid on inst_bus (gnt, rvalid next cycle, IF/ID load on the following edge).
- Reset mid-transaction returns to S_REQ; stale responses are dropped by the S_REQ ignore rule.

Test Plan:
1. Reset, then memory with gnt same cycle and rvalid next cycle, supplying instructions 0xE2811001 at 0 and 0xE2822002 at 4 -> imem_addr sequence 0, 4, 8.
   - inst_bus shows 0xE2811001 with pc_plus8_d=8, then 0xE2822002 with pc_plus8_d=12.
   - valid_d=1 on both.
2. BranchTakenE=1, ALUResultE=0x40 while in S_WAIT for address 8 -> response for 8 is discarded and the next imem_addr is 0x40.
   - With FlushD pulsed, inst_bus=NOP_INSTR and valid_d=0.
3. BranchTakenE=1 (target 0x80) and PCSrcW=1 (ResultW 0x100) in the same cycle -> next request address is 0x80.
4. StallD held for 3 cycles with the buffer full -> inst_bus unchanged and imem_req=0 after the buffer fills.
   - On release, the buffered instruction loads with no bubble.
5. Memory withholds rvalid for 5 cycles -> fetch_bubble=1 and valid_d=0 each cycle until data arrives; PCF advances exactly once.
6. reset asserted while in S_WAIT, with the stale rvalid arriving the cycle after reset -> rvalid ignored, imem_addr=RESET_PC, inst_bus=NOP_INSTR.
